// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main controller: Moore sequencer driving the datapath
// mux selects and write strobes for PC, IR, register file and memory.
module mc_control_fsm #(
   parameter bit MEM_WAIT_EN = 1'b1,
   parameter bit EXT_OPS     = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] OPCode,
   input  logic       MemReady,
   output logic       IorD,
   output logic       ALUSrcA,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSrc,
   output logic [2:0] ALUOp,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic       Branch,
   output logic       BranchNE,
   output logic       Illegal,
   output logic [3:0] State
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECUTE = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_IMMEX   = 4'd9,
      S_IMMWB   = 4'd10,
      S_JUMP    = 4'd11
   } state_t;

   state_t     state;
   state_t     dec_next;
   logic       dec_ill;
   logic [5:0] op_q;
   logic       mem_rdy;

   assign mem_rdy = MEM_WAIT_EN ? MemReady : 1'b1;
   assign State   = 4'(state);

   // Opcode dispatch used on the DECODE cycle
   always_comb begin
      dec_next = S_FETCH;
      dec_ill  = 1'b0;
      case (OPCode)
         OP_RTYPE:       dec_next = S_EXECUTE;
         OP_LW, OP_SW:   dec_next = S_MEMADR;
         OP_BEQ:         dec_next = S_BRANCH;
         OP_BNE:         if (EXT_OPS) dec_next = S_BRANCH; else dec_ill = 1'b1;
         OP_ADDI:        dec_next = S_IMMEX;
         OP_ANDI, OP_ORI: if (EXT_OPS) dec_next = S_IMMEX; else dec_ill = 1'b1;
         OP_J:           dec_next = S_JUMP;
         default:        dec_ill = 1'b1;
      endcase
   end

   // State register and latched opcode; unreachable codes fall back to FETCH
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_FETCH;
         op_q  <= 6'd0;
      end else begin
         case (state)
            S_FETCH:   if (mem_rdy) state <= S_DECODE;
            S_DECODE: begin
               op_q  <= OPCode;
               state <= dec_next;
            end
            S_MEMADR:  state <= (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (mem_rdy) state <= S_MEMWB;
            S_MEMWB:   state <= S_FETCH;
            S_MEMWR:   if (mem_rdy) state <= S_FETCH;
            S_EXECUTE: state <= S_ALUWB;
            S_ALUWB:   state <= S_FETCH;
            S_BRANCH:  state <= S_FETCH;
            S_IMMEX:   state <= S_IMMWB;
            S_IMMWB:   state <= S_FETCH;
            S_JUMP:    state <= S_FETCH;
            default:   state <= S_FETCH;
         endcase
      end
   end

   // Moore output decode; strobes are held low while reset is asserted
   always_comb begin
      IorD     = 1'b0;
      ALUSrcA  = 1'b0;
      RegDst   = 1'b0;
      MemtoReg = 1'b0;
      ALUSrcB  = 2'b00;
      PCSrc    = 2'b00;
      ALUOp    = 3'b000;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      Branch   = 1'b0;
      BranchNE = 1'b0;
      Illegal  = 1'b0;
      case (state)
         S_FETCH: begin
            ALUSrcB = 2'b01;
            IRWrite = mem_rdy;
            PCWrite = mem_rdy;
         end
         S_DECODE: begin
            ALUSrcB = 2'b11;
            Illegal = dec_ill;
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_MEMRD:  IorD = 1'b1;
         S_MEMWB: begin
            MemtoReg = 1'b1;
            RegWrite = 1'b1;
         end
         S_MEMWR: begin
            IorD     = 1'b1;
            MemWrite = 1'b1;
         end
         S_EXECUTE: begin
            ALUSrcA = 1'b1;
            ALUOp   = 3'b010;
         end
         S_ALUWB: begin
            RegDst   = 1'b1;
            RegWrite = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA  = 1'b1;
            ALUOp    = 3'b001;
            PCSrc    = 2'b01;
            Branch   = (op_q == OP_BEQ);
            BranchNE = EXT_OPS && (op_q == OP_BNE);
         end
         S_IMMEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            if (op_q == OP_ANDI)     ALUOp = 3'b011;
            else if (op_q == OP_ORI) ALUOp = 3'b100;
         end
         S_IMMWB:  RegWrite = 1'b1;
         S_JUMP: begin
            PCSrc   = 2'b10;
            PCWrite = 1'b1;
         end
         default: ;
      endcase
      if (!rst_n) begin
         IRWrite  = 1'b0;
         PCWrite  = 1'b0;
         MemWrite = 1'b0;
         RegWrite = 1'b0;
         Branch   = 1'b0;
         BranchNE = 1'b0;
         Illegal  = 1'b0;
      end
   end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: two instances (full feature set, and
// no-wait/no-extension), random instruction streams, per-cycle expectations.
module tb_mc_control_fsm;

   typedef struct packed {
      logic [3:0] st;
      logic       iord, srca, regdst, memtoreg;
      logic [1:0] srcb, pcsrc;
      logic [2:0] aluop;
      logic       irw, pcw, memw, regw, br, brne, ill;
   } rec_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_J    = 6'b000010;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] op_a = 6'd0, op_b = 6'd0;
   logic       mr_a = 1'b1, mr_b = 1'b1;

   logic       iord_a, srca_a, regdst_a, memtoreg_a, irw_a, pcw_a, memw_a, regw_a, br_a, brne_a, ill_a;
   logic [1:0] srcb_a, pcsrc_a;
   logic [2:0] aluop_a;
   logic [3:0] st_a;
   logic       iord_b, srca_b, regdst_b, memtoreg_b, irw_b, pcw_b, memw_b, regw_b, br_b, brne_b, ill_b;
   logic [1:0] srcb_b, pcsrc_b;
   logic [2:0] aluop_b;
   logic [3:0] st_b;

   rec_t act_a, act_b, ea, eb;
   rec_t qa[$];
   rec_t qb[$];
   int   n_checks = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   mc_control_fsm #(.MEM_WAIT_EN(1'b1), .EXT_OPS(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n), .OPCode(op_a), .MemReady(mr_a),
      .IorD(iord_a), .ALUSrcA(srca_a), .RegDst(regdst_a), .MemtoReg(memtoreg_a),
      .ALUSrcB(srcb_a), .PCSrc(pcsrc_a), .ALUOp(aluop_a),
      .IRWrite(irw_a), .PCWrite(pcw_a), .MemWrite(memw_a), .RegWrite(regw_a),
      .Branch(br_a), .BranchNE(brne_a), .Illegal(ill_a), .State(st_a));

   mc_control_fsm #(.MEM_WAIT_EN(1'b0), .EXT_OPS(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n), .OPCode(op_b), .MemReady(mr_b),
      .IorD(iord_b), .ALUSrcA(srca_b), .RegDst(regdst_b), .MemtoReg(memtoreg_b),
      .ALUSrcB(srcb_b), .PCSrc(pcsrc_b), .ALUOp(aluop_b),
      .IRWrite(irw_b), .PCWrite(pcw_b), .MemWrite(memw_b), .RegWrite(regw_b),
      .Branch(br_b), .BranchNE(brne_b), .Illegal(ill_b), .State(st_b));

   assign act_a = {st_a, iord_a, srca_a, regdst_a, memtoreg_a, srcb_a, pcsrc_a, aluop_a,
                   irw_a, pcw_a, memw_a, regw_a, br_a, brne_a, ill_a};
   assign act_b = {st_b, iord_b, srca_b, regdst_b, memtoreg_b, srcb_b, pcsrc_b, aluop_b,
                   irw_b, pcw_b, memw_b, regw_b, br_b, brne_b, ill_b};

   // Reference: state path an instruction walks (-1 marks end of instruction)
   function automatic int phase_state(input logic [5:0] op, input bit ext, input int i);
      int s[5];
      s = '{0, 1, -1, -1, -1};
      if (op == OP_R)                                         s = '{0, 1, 6, 7, -1};
      else if (op == OP_LW)                                   s = '{0, 1, 2, 3, 4};
      else if (op == OP_SW)                                   s = '{0, 1, 2, 5, -1};
      else if (op == OP_BEQ || (ext && op == OP_BNE))         s = '{0, 1, 8, -1, -1};
      else if (op == OP_ADDI || (ext && (op == OP_ANDI || op == OP_ORI)))
                                                              s = '{0, 1, 9, 10, -1};
      else if (op == OP_J)                                    s = '{0, 1, 11, -1, -1};
      return (i < 5) ? s[i] : -1;
   endfunction

   // Reference: outputs expected in a given state of a given instruction
   function automatic rec_t exp_out(input int st, input logic [5:0] op, input logic mr,
                                    input bit wait_en, input bit ext);
      rec_t r;
      logic m;
      r = '0;
      m = wait_en ? mr : 1'b1;
      r.st = 4'(st);
      case (st)
         0:  begin r.srcb = 2'b01; r.irw = m; r.pcw = m; end
         1:  begin r.srcb = 2'b11; r.ill = (phase_state(op, ext, 2) < 0); end
         2:  begin r.srca = 1'b1; r.srcb = 2'b10; end
         3:  r.iord = 1'b1;
         4:  begin r.memtoreg = 1'b1; r.regw = 1'b1; end
         5:  begin r.iord = 1'b1; r.memw = 1'b1; end
         6:  begin r.srca = 1'b1; r.aluop = 3'b010; end
         7:  begin r.regdst = 1'b1; r.regw = 1'b1; end
         8:  begin r.srca = 1'b1; r.aluop = 3'b001; r.pcsrc = 2'b01;
                   r.br = (op == OP_BEQ); r.brne = (op == OP_BNE); end
         9:  begin r.srca = 1'b1; r.srcb = 2'b10;
                   r.aluop = (op == OP_ANDI) ? 3'b011 : (op == OP_ORI) ? 3'b100 : 3'b000; end
         10: r.regw = 1'b1;
         11: begin r.pcsrc = 2'b10; r.pcw = 1'b1; end
         default: ;
      endcase
      return r;
   endfunction

   function automatic logic [5:0] pick(input bit b, input int k);
      int r;
      if (!b) begin
         case (k)
            0: return OP_LW;   1: return OP_SW;   2: return OP_BEQ;
            3: return OP_BNE;  4: return OP_ORI;  5: return OP_J;
            6: return OP_ANDI; 7: return OP_ADDI; 8: return OP_R;
            default: ;
         endcase
      end else begin
         case (k)
            0: return OP_ORI;  1: return OP_J;    2: return OP_BNE;
            3: return OP_ANDI; 4: return OP_LW;   5: return OP_SW;
            default: ;
         endcase
      end
      r = int'($urandom_range(0, 11));
      case (r)
         0: return OP_R;    1: return OP_LW;   2: return OP_SW;
         3: return OP_BEQ;  4: return OP_BNE;  5: return OP_ADDI;
         6: return OP_ANDI; 7: return OP_ORI;  8: return OP_J;
         default: return 6'($urandom);
      endcase
   endfunction

   task automatic check(input string nm, input rec_t act, input rec_t exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s t=%0t got=%h (state %0d) expected=%h (state %0d)",
                    nm, $time, act, act.st, exp, exp.st);
   endtask

   // Stimulus: drive one instruction stream, pushing per-cycle expectations
   task automatic run(input bit b, input int n);
      bit         we, ex;
      logic [5:0] op;
      logic       mr;
      int         st;
      we = !b;
      ex = !b;
      for (int k = 0; k < n; k++) begin
         op = pick(b, k);
         for (int i = 0; phase_state(op, ex, i) >= 0; i++) begin
            st = phase_state(op, ex, i);
            do begin
               mr = ($urandom_range(0, 9) < 6);
               if (b) begin
                  mr_b = mr;
                  op_b = (st == 1) ? op : 6'($urandom);
                  qb.push_back(exp_out(st, op, mr, we, ex));
               end else begin
                  mr_a = mr;
                  op_a = (st == 1) ? op : 6'($urandom);
                  qa.push_back(exp_out(st, op, mr, we, ex));
               end
               @(posedge clk);
               #1;
            end while (we && !mr && (st == 0 || st == 3 || st == 5));
         end
      end
   endtask

   // Monitors: compare every cycle that has a pending expectation
   always @(negedge clk) begin
      if (qa.size() != 0) begin
         ea = qa.pop_front();
         check("cycle_a", act_a, ea);
      end
      if (qb.size() != 0) begin
         eb = qb.pop_front();
         check("cycle_b", act_b, eb);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog t=%0t got=stuck required=finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rec_t e;
      bit   found;
      #2;
      // Reset held: FETCH selects, strobes low even with MemReady high
      e = exp_out(0, OP_R, 1'b1, 1'b1, 1'b1); e.irw = 1'b0; e.pcw = 1'b0;
      check("reset_a", act_a, e);
      check("reset_b", act_b, e);

      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      op_a = OP_R; op_b = OP_R; mr_a = 1'b1; mr_b = 1'b0;
      found = 1'b0;
      for (int t = 0; t < 10 && !found; t++) begin
         @(negedge clk);
         if (st_a == 4'd6) found = 1'b1;
      end
      if (!found) begin
         n_checks++;
         $display("FAIL reach_execute got=state %0d required=state 6", st_a);
      end

      // Asynchronous reset mid-EXECUTE
      #1 rst_n = 1'b0;
      #1;
      e = exp_out(0, OP_R, 1'b1, 1'b1, 1'b1); e.irw = 1'b0; e.pcw = 1'b0;
      check("async_reset_a", act_a, e);
      check("async_reset_b", act_b, e);
      #1 rst_n = 1'b1;
      #1;
      check("fetch_after_rel_a", act_a, exp_out(0, OP_R, mr_a, 1'b1, 1'b1));
      check("fetch_after_rel_b", act_b, exp_out(0, OP_R, mr_b, 1'b0, 1'b0));
      @(posedge clk);
      #1;
      check("decode_after_rel_a", act_a, exp_out(1, op_a, mr_a, 1'b1, 1'b1));
      check("decode_after_rel_b", act_b, exp_out(1, op_b, mr_b, 1'b0, 1'b0));

      // Clean restart, then concurrent random streams
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      fork
         run(1'b0, 60);
         run(1'b1, 60);
      join
      repeat (3) @(posedge clk);
      if (qa.size() != 0 || qb.size() != 0) begin
         n_checks++;
         $display("FAIL drain got=%0d/%0d pending required=0/0", qa.size(), qb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multicycle successor to the single-cycle main decoder: a Moore state machine that sequences each MIPS instruction over 3–5 cycles, plus optional memory wait states. It sits in the multicycle datapath's controller next to the ALU decoder, and drives the multiplexer selects and write strobes for PC, IR, register file and unified memory. It is parametrised for an optional memory-ready handshake and an extended opcode set (bne, andi, ori). Illegal opcodes are flagged instead of producing don't-cares.

## Interface
- MEM_WAIT_EN, 1: 1 = honour MemReady; 0 = MemReady treated as constant 1.
- EXT_OPS, 1: 1 = decode bne (000101), andi (001100), ori (001101); 0 = these are illegal.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- OPCode  in  6  instr[31:26] from the IR; sampled only in DECODE.
- MemReady  in  1  memory completes the current access this cycle.
- IorD, ALUSrcA, RegDst, MemtoReg  out  1 each  datapath mux selects.
- ALUSrcB  out  2  00 = rB, 01 = const 4, 10 = SignImm, 11 = SignImm<<2.
- PCSrc  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target.
- ALUOp  out  3  000 = add, 001 = sub, 010 = use funct, 011 = and, 100 = or.
- IRWrite, PCWrite, MemWrite, RegWrite, Branch, BranchNE  out  1 each  strobes.
- Illegal  out  1  one-cycle pulse for an unsupported opcode.
- State  out  4  current state code, for debug.

## Operation
- Encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, IMMEX=9, IMMWB=10, JUMP=11.
  - Codes 12–15 are unreachable and transition to FETCH.
- Outputs are a pure function of State (and MemReady, where noted). Unlisted strobes are 0; unlisted selects are 0.
- FETCH:
  - IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSrc=00.
  - IRWrite = PCWrite = MemReady.
  - Stay in FETCH while MemReady=0; go to DECODE when MemReady=1.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALUOp=000 (branch target computed into ALUOut).
  - Next state by OPCode:
    - 000000 → EXECUTE
    - 100011 / 101011 → MEMADR
    - 000100 → BRANCH
    - 000101 → BRANCH (EXT_OPS only)
    - 001000, 001100, 001101 → IMMEX (the last two only with EXT_OPS)
    - 000010 → JUMP
    - anything else → FETCH, with Illegal=1 for this cycle.
  - The opcode is latched into an internal 6-bit register on the DECODE cycle and used for the later states.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=000. Go to MEMRD (lw) or MEMWR (sw).
- MEMRD: IorD=1. Hold while MemReady=0; then go to MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Go to FETCH.
- MEMWR: IorD=1, MemWrite=1 held every cycle until MemReady=1, then go to FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=010. Go to ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Go to FETCH.
- BRANCH:
  - ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSrc=01.
  - Branch=1 for beq; BranchNE=1 for bne (never both).
  - Go to FETCH.
- IMMEX: ALUSrcA=1, ALUSrcB=10; ALUOp=000 (addi) / 011 (andi) / 100 (ori). Go to IMMWB.
  - Zero-extension for andi/ori is handled by the datapath and is outside this block.
- IMMWB: RegDst=0, MemtoReg=0, RegWrite=1. Go to FETCH.
- JUMP: PCSrc=10, PCWrite=1. Go to FETCH.

## Timing
- Reset:
  - rst_n low forces State=FETCH and clears the latched opcode immediately (asynchronous).
  - While rst_n is low, IRWrite, PCWrite, MemWrite, RegWrite, Branch, BranchNE and Illegal are forced to 0. Selects take their FETCH values.
  - Reset release is synchronous to the first rising clk edge after rst_n goes high.
- Cycles per instruction with zero wait (count includes FETCH):
  - lw 5; sw 4; R-type 4; addi/andi/ori 4; beq/bne 3; j 3.
  - Illegal: 2 cycles (FETCH, DECODE).
- Each cycle with MemReady=0 in FETCH, MEMRD or MEMWR adds one cycle. There is no timeout.
- With MEM_WAIT_EN=0, MemReady is ignored and the latencies above are exact.
- Reset mid-instruction aborts it; no strobe fires on the reset cycle.
- Exactly one of IRWrite / RegWrite / MemWrite / (Branch | BranchNE) may be high in any cycle, except FETCH, where IRWrite and PCWrite are high together.

## Test plan
- Reset: rst_n=0 mid-EXECUTE, asynchronously → State=0 immediately and all strobes 0; after release, FETCH with MemReady=1 → IRWrite=PCWrite=1, next State=1.
- lw, MEM_WAIT_EN=1, MemReady low for 2 cycles in MEMRD → State sequence 0,1,2,3,3,3,4,0; RegWrite=1 only in State 4, with MemtoReg=1.
- sw, MemReady=1 → sequence 0,1,2,5,0; MemWrite=1 for exactly one cycle, with IorD=1.
- beq then bne (EXT_OPS=1) → 0,1,8 each; Branch=1, BranchNE=0, then BranchNE=1, Branch=0; ALUOp=001, PCSrc=01.
- ori with EXT_OPS=1 → 0,1,9,10,0 with ALUOp=100 in IMMEX. Same opcode with EXT_OPS=0 → Illegal pulses in DECODE, then State=0.
- j, MEM_WAIT_EN=0 with MemReady tied to 0 → 0,1,11,0; PCSrc=10, PCWrite=1 in JUMP.
